aes_key_expander: RTL

//  Sequential AES key expansion (FIPS-197) for 128/192/256-bit keys, one 32-bit word per clock.

---
 rtl/aes_key_expander.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/aes_key_expander.sv
// Sequential AES key expansion for 128/192/256-bit keys, one word per clock.
// Round keys are kept in a word store and read back by round index.

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign y = SBOX[a];

endmodule

module aes_key_expander #(
    parameter int MAX_KEY_BITS = 256,
    parameter bit OUT_REG      = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [1:0]              key_len,
    input  logic [MAX_KEY_BITS-1:0] key_in,
    output logic                    ready,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    rk_valid,
    output logic [3:0]              num_rounds,
    input  logic [3:0]              rk_idx,
    output logic [127:0]            rk_out
);

    localparam int MAX_NK = MAX_KEY_BITS / 32;
    localparam int MAX_NR = MAX_NK + 6;
    localparam int SW     = 4 * (MAX_NR + 1);
    localparam int AW     = $clog2(SW);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXPAND,
        S_DONE
    } state_t;

    state_t        state, state_n;
    logic [AW-1:0] idx;
    logic [3:0]    nk;
    logic [3:0]    nr;
    logic [2:0]    cnt;
    logic [7:0]    rcon;
    logic [31:0]   store [SW];

    logic [3:0]    nk_req;
    logic          key_ok;
    logic          accept;
    logic          reject;
    logic          last;
    logic [7:0]    t_last;
    logic [7:0]    i8;
    logic [7:0]    prev8;
    logic [7:0]    old8;
    logic [31:0]   w_prev;
    logic [31:0]   w_old;
    logic [31:0]   sub_in;
    logic [31:0]   sub_out;
    logic [31:0]   t_word;
    logic [31:0]   w_new;
    logic          rd_hit;
    logic [7:0]    rd_base;
    logic [127:0]  rd_word;

    // Decode the requested key size and reject sizes this instance cannot hold.
    always_comb begin
        nk_req = 4'd0;
        unique case (key_len)
            2'b00:   nk_req = 4'd4;
            2'b01:   nk_req = 4'd6;
            2'b10:   nk_req = 4'd8;
            default: nk_req = 4'd0;
        endcase
        key_ok = (nk_req != 4'd0) && (32 * int'(nk_req) <= MAX_KEY_BITS);
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_n = state;
        ready   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        accept  = 1'b0;
        reject  = 1'b0;
        unique case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    if (key_ok) begin
                        accept  = 1'b1;
                        state_n = S_EXPAND;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            S_EXPAND: begin
                busy = 1'b1;
                if (last) state_n = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Word update: w[i] = w[i-Nk] ^ t, indices kept inside the store.
    always_comb begin
        t_last = ({4'd0, nr} + 8'd1) * 8'd4 - 8'd1;
        i8     = 8'(idx);
        last   = (i8 == t_last);
        prev8  = (i8 == 8'd0) ? 8'(SW - 1) : i8 - 8'd1;
        if (i8 >= {4'd0, nk}) old8 = i8 - {4'd0, nk};
        else                  old8 = i8 + 8'(SW) - {4'd0, nk};
        w_prev = store[AW'(prev8)];
        w_old  = store[AW'(old8)];
        sub_in = (cnt == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
        if (cnt == 3'd0)
            t_word = sub_out ^ {rcon, 24'h0};
        else if (nk == 4'd8 && cnt == 3'd4)
            t_word = sub_out;
        else
            t_word = w_prev;
        w_new = w_old ^ t_word;
    end

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .a (sub_in[8*b +: 8]),
            .y (sub_out[8*b +: 8])
        );
    end

    // State register and expansion bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            idx        <= '0;
            nk         <= 4'd0;
            nr         <= 4'd0;
            cnt        <= 3'd0;
            rcon       <= 8'h01;
            rk_valid   <= 1'b0;
            num_rounds <= 4'd0;
            err        <= 1'b0;
        end else begin
            state <= state_n;
            err   <= reject;
            if (accept) begin
                idx      <= AW'(nk_req);
                nk       <= nk_req;
                nr       <= nk_req + 4'd6;
                cnt      <= 3'd0;
                rcon     <= 8'h01;
                rk_valid <= 1'b0;
            end
            if (state == S_EXPAND) begin
                idx <= idx + AW'(1);
                cnt <= (cnt == 3'(nk - 4'd1)) ? 3'd0 : cnt + 3'd1;
                if (cnt == 3'd0)
                    rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                if (last) begin
                    rk_valid   <= 1'b1;
                    num_rounds <= nr;
                end
            end
        end
    end

    // Word store: key words on accept, one expanded word per EXPAND cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int j = 0; j < MAX_NK; j++) begin
                if (j < int'(nk_req))
                    store[j] <= key_in[MAX_KEY_BITS-1-32*j -: 32];
            end
        end else if (state == S_EXPAND) begin
            store[idx] <= w_new;
        end
    end

    // Read port: zero unless a complete schedule holds the requested round.
    always_comb begin
        rd_hit  = rk_valid && (rk_idx <= num_rounds);
        rd_base = rd_hit ? {2'b00, rk_idx, 2'b00} : 8'd0;
        rd_word = {store[AW'(rd_base)],
                   store[AW'(rd_base + 8'd1)],
                   store[AW'(rd_base + 8'd2)],
                   store[AW'(rd_base + 8'd3)]};
        if (!rd_hit) rd_word = 128'h0;
    end

    if (OUT_REG) begin : g_out_reg
        logic [127:0] rk_q;

        // One-cycle registered read.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) rk_q <= 128'h0;
            else     rk_q <= rd_word;
        end

        assign rk_out = rk_q;
    end else begin : g_out_comb
        assign rk_out = rd_word;
    end

endmodule
